exp_bit_scanner: RTL and testbench

- Serializes an exponent operand MSB-first for the modular-exponentiation datapath of the security accelerator.
- Counts the used bits of the operand and skips leading zeros.
- Emits each significant bit over a valid/ready handshake so the square-and-multiply sequencer can consume one bit per step.
- Bit order: the highest set bit is emitted first, bit 0 is emitted last.

---
 rtl/sec_acc_pkg.sv | 8 +
 rtl/exp_bit_scanner_if.sv | 24 ++
 rtl/msb_locator.sv | 13 +
 rtl/exp_bit_scanner.sv | 70 +++++++
 tb/tb_exp_bit_scanner.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/sec_acc_pkg.sv
// sec_acc_pkg: shared scanner state encoding, default width and count-width helper
package sec_acc_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;
  function automatic int clog2_plus1(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/exp_bit_scanner_if.sv
// exp_bit_scanner_if: scanner bus; slave = scanner (start/exp_in/bit_ready/abort in, busy/nbits/bit_*/done/zero_exp out), master = sequencer; abort exists only with EXP_SCAN_ABORT_EN
interface exp_bit_scanner_if import sec_acc_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = clog2_plus1(WIDTH)
);
  logic             start;
  logic [WIDTH-1:0] exp_in;
  logic             busy;
  logic [CNT_W-1:0] nbits;
  logic             bit_valid;
  logic             bit_out;
  logic             bit_last;
  logic             bit_ready;
  logic             done;
  logic             zero_exp;
`ifdef EXP_SCAN_ABORT_EN
  logic             abort;
  modport slave  (input start, exp_in, bit_ready, abort, output busy, nbits, bit_valid, bit_out, bit_last, done, zero_exp);
  modport master (output start, exp_in, bit_ready, abort, input busy, nbits, bit_valid, bit_out, bit_last, done, zero_exp);
`else
  modport slave  (input start, exp_in, bit_ready, output busy, nbits, bit_valid, bit_out, bit_last, done, zero_exp);
  modport master (output start, exp_in, bit_ready, input busy, nbits, bit_valid, bit_out, bit_last, done, zero_exp);
`endif
endinterface

// File: rtl/msb_locator.sv
// msb_locator: used-bit count (highest set bit + 1, 0 for zero) of i_val on o_cnt
module msb_locator import sec_acc_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = clog2_plus1(WIDTH)
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [CNT_W-1:0] o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < WIDTH; i++) if (i_val[i]) o_cnt = CNT_W'(i + 1);
  end
endmodule

// File: rtl/exp_bit_scanner.sv
// exp_bit_scanner: MSB-first exponent bit serializer skipping leading zeros; ports clk, rst, bus (slave modport); abort input added when EXP_SCAN_ABORT_EN is defined
module exp_bit_scanner import sec_acc_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = clog2_plus1(WIDTH)
) (
  input logic clk,
  input logic rst,
  exp_bit_scanner_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_shadow, w_shadow_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic [CNT_W-1:0] r_nbits, w_nbits_nx;
  logic [CNT_W-1:0] w_cnt;
  logic             w_abort;
  msb_locator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_loc (.i_val(r_shadow), .o_cnt(w_cnt));
`ifdef EXP_SCAN_ABORT_EN
  assign w_abort = bus.abort && (r_state == LOAD || r_state == SCAN);
`else
  assign w_abort = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_nbits  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_shadow <= w_shadow_nx;
      r_idx    <= w_idx_nx;
      r_nbits  <= w_nbits_nx;
    end
  end
  always_comb begin
    w_state_nx  = r_state;
    w_shadow_nx = r_shadow;
    w_idx_nx    = r_idx;
    w_nbits_nx  = r_nbits;
    unique case (r_state)
      IDLE: begin
        w_shadow_nx = bus.start ? bus.exp_in : r_shadow;
        w_state_nx  = bus.start ? LOAD : IDLE;
      end
      LOAD: begin
        w_nbits_nx = w_cnt;
        w_idx_nx   = IDX_W'(w_cnt - CNT_W'(1));
        w_state_nx = (w_cnt == '0) ? DONE : SCAN;
      end
      SCAN: begin
        w_idx_nx   = (bus.bit_ready && r_idx != '0) ? r_idx - IDX_W'(1) : r_idx;
        w_state_nx = (bus.bit_ready && r_idx == '0) ? DONE : SCAN;
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_abort) begin
      w_state_nx = IDLE;
      w_idx_nx   = r_idx;
      w_nbits_nx = r_nbits;
    end
  end
  assign bus.busy      = r_state != IDLE;
  assign bus.nbits     = r_nbits;
  assign bus.bit_valid = r_state == SCAN;
  assign bus.bit_out   = bus.bit_valid && r_shadow[r_idx];
  assign bus.bit_last  = bus.bit_valid && r_idx == '0;
  assign bus.done      = r_state == DONE;
  assign bus.zero_exp  = bus.done && r_nbits == '0;
endmodule

// File: tb/tb_exp_bit_scanner.sv
// tb_exp_bit_scanner: directed scoreboard bench for exp_bit_scanner
module tb_exp_bit_scanner;
  import sec_acc_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int cyc;
  int x0;
  logic b;
  logic [5:0] pat;
  logic [1:0] m_e;
  logic [1:0] sb[$];
  always #5 clk = ~clk;
  exp_bit_scanner_if #(.WIDTH(32), .CNT_W(6)) bus ();
  exp_bit_scanner #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [31:0] v);
    int top;
    top = -1;
    for (int i = 31; i >= 0; i--) if (v[i] && top < 0) top = i;
    for (int i = top; i >= 0; i--) sb.push_back({v[i], i == 0});
  endtask

  task automatic do_start(input logic [31:0] v);
    push_bits(v);
    bus.start = 1'b1;
    bus.exp_in = v;
    tick();
    bus.start = 1'b0;
    chk("load_busy", bus.busy, 1);
    chk("load_valid", bus.bit_valid, 0);
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bus.done) begin
        c = i;
        break;
      end
    end
  endtask

  always @(negedge clk) if (bus.bit_valid && bus.bit_ready) begin
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      m_e = sb.pop_front();
      chk("bit_out", bus.bit_out, m_e[1]);
      chk("bit_last", bus.bit_last, m_e[0]);
    end
    n_xfer++;
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.exp_in = '0;
    bus.bit_ready = 1'b1;
`ifdef EXP_SCAN_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.bit_valid, 0);
    chk("rst_out", bus.bit_out, 0);
    chk("rst_last", bus.bit_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_zero", bus.zero_exp, 0);
    chk("rst_nbits", bus.nbits, 0);

    x0 = n_xfer;
    do_start(32'h0000_000B);
    tick();
    chk("b_nbits", bus.nbits, 4);
    chk("b_valid", bus.bit_valid, 1);
    wait_done(cyc);
    chk("b_done_lat", cyc, 4);
    chk("b_zero", bus.zero_exp, 0);
    chk("b_done_valid", bus.bit_valid, 0);
    chk("b_xfers", n_xfer - x0, 4);
    bus.start = 1'b1;
    bus.exp_in = 32'h1;
    tick();
    bus.start = 1'b0;
    chk("done_start_ignored", bus.busy, 0);
    chk("b_done_pulse", bus.done, 0);

    do_start(32'h0);
    tick();
    chk("z_done", bus.done, 1);
    chk("z_zero", bus.zero_exp, 1);
    chk("z_nbits", bus.nbits, 0);
    chk("z_valid", bus.bit_valid, 0);
    tick();
    chk("z_idle", bus.busy, 0);
    chk("z_zero_pulse", bus.zero_exp, 0);

    x0 = n_xfer;
    do_start(32'h8000_0000);
    tick();
    chk("m_nbits", bus.nbits, 32);
    wait_done(cyc);
    chk("m_done_lat", cyc, 32);
    chk("m_xfers", n_xfer - x0, 32);
    tick();

    pat = 6'b101001;
    do_start(32'h5);
    tick();
    chk("s_nbits", bus.nbits, 3);
    for (int i = 0; i < 6; i++) begin
      bus.bit_ready = pat[i];
      b = bus.bit_out;
      tick();
      if (!pat[i]) begin
        chk("stall_valid", bus.bit_valid, 1);
        chk("stall_bit", bus.bit_out, b);
      end
    end
    chk("s_done", bus.done, 1);
    bus.bit_ready = 1'b1;
    tick();

    do_start(32'h4);
    tick();
    bus.start = 1'b1;
    bus.exp_in = 32'h7;
    tick();
    bus.start = 1'b0;
    chk("r_bit2", bus.bit_out, 0);
    chk("r_nbits", bus.nbits, 3);
    bus.bit_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("r_busy", bus.busy, 0);
    chk("r_valid", bus.bit_valid, 0);
    chk("r_out", bus.bit_out, 0);
    chk("r_nbits0", bus.nbits, 0);
    chk("r_done", bus.done, 0);
    tick();
    chk("r_no_done", bus.done, 0);
    bus.bit_ready = 1'b1;
    x0 = n_xfer;
    do_start(32'h3);
    tick();
    chk("f_nbits", bus.nbits, 2);
    wait_done(cyc);
    chk("f_done_lat", cyc, 2);
    chk("f_xfers", n_xfer - x0, 2);
    tick();

`ifdef EXP_SCAN_ABORT_EN
    do_start(32'hF);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    sb.delete();
    chk("a_valid", bus.bit_valid, 0);
    chk("a_busy", bus.busy, 0);
    chk("a_done", bus.done, 0);
    chk("a_nbits", bus.nbits, 4);
    tick();
    chk("a_no_done", bus.done, 0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
